// File: rtl/hex_raster_batch_scheduler.sv
// Packs round-robin hex samples into one 10-lane rasterizer batch and drains results tagged by requester.
// Latency: issue 1 cycle after the last accept, results 1 cycle after rast_valid_out; req_ready held low and res_* held stable under res_ready=0.
module hex_raster_batch_scheduler #(
   parameter int LANES   = 10,
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_q_f,
   input  logic [NUM_REQ*32-1:0]  req_r_f,
   input  logic [NUM_REQ*32-1:0]  req_s_f,
   input  logic                   flush,
   output logic                   rast_valid_in,
   output logic [LANES*32-1:0]    rast_q_f,
   output logic [LANES*32-1:0]    rast_r_f,
   output logic [LANES*32-1:0]    rast_s_f,
   input  logic                   rast_valid_out,
   input  logic [LANES*16-1:0]    rast_q,
   input  logic [LANES*16-1:0]    rast_r,
   input  logic [LANES*8-1:0]     rast_depth,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ID_W-1:0]        res_id,
   output logic [15:0]            res_q,
   output logic [15:0]            res_r,
   output logic [7:0]             res_depth,
   output logic                   busy,
   output logic                   err_unexpected
);

   localparam int CNT_W = $clog2(LANES + 1);
   localparam int IDX_W = $clog2(LANES);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NUM_REQ);

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     q_f;
      logic [31:0]     r_f;
      logic [31:0]     s_f;
   } lane_t;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic [7:0]  depth;
   } res_t;

   typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [TMR_W-1:0]  timer;
   logic [ID_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]  idx;
   lane_t             lane    [LANES];
   res_t              res_buf [LANES];

   logic              gnt_vld;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W:0]     cand;
   lane_t             new_lane;
   logic              hs;
   logic              last_acc;
   logic              early;

   // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      cand     = '0;
      new_lane = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (ID_W + 1)'(i);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!gnt_vld && req_valid[cand[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand[ID_W-1:0];
         end
      end
      new_lane.id  = gnt_id;
      new_lane.q_f = req_q_f[32*int'(gnt_id) +: 32];
      new_lane.r_f = req_r_f[32*int'(gnt_id) +: 32];
      new_lane.s_f = req_s_f[32*int'(gnt_id) +: 32];
   end

   assign hs        = (state == FILL) && gnt_vld;
   assign req_ready = (reset_n && hs) ? (NUM_REQ'(1) << gnt_id) : '0;
   assign last_acc  = hs && (count == CNT_W'(LANES - 1));
   assign early     = (count != '0) && ((timer == TMR_W'(TIMEOUT - 1)) || flush);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= FILL;
         count          <= '0;
         timer          <= '0;
         rr_ptr         <= '0;
         idx            <= '0;
         err_unexpected <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            lane[l]    <= '0;
            res_buf[l] <= '0;
         end
      end else begin
         if (rast_valid_out && state != WAIT) err_unexpected <= 1'b1;
         case (state)
            FILL: begin
               if (count != '0) timer <= timer + 1'b1;
               if (hs) begin
                  for (int l = 0; l < LANES; l++)
                     if (CNT_W'(l) == count) lane[l] <= new_lane;
                  count  <= count + 1'b1;
                  rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
               end
               // A sample handshaken alongside a timeout/flush still joins this batch.
               if (last_acc || early) state <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (rast_valid_out) begin
                  for (int l = 0; l < LANES; l++)
                     if (CNT_W'(l) < count)
                        res_buf[l] <= '{q:     rast_q[16*l +: 16],
                                        r:     rast_r[16*l +: 16],
                                        depth: rast_depth[8*l +: 8]};
                  idx   <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (res_ready) begin
                  if (CNT_W'(idx) + 1'b1 == count) begin
                     state <= FILL;
                     count <= '0;
                     timer <= '0;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign rast_valid_in = (state == ISSUE);
   assign res_valid     = (state == DRAIN);
   assign busy          = (state != FILL) || (count != '0);

   // Unused lanes launch as zero so the rasterizer sees clean operands.
   always_comb begin
      rast_q_f = '0;
      rast_r_f = '0;
      rast_s_f = '0;
      if (state == ISSUE) begin
         for (int l = 0; l < LANES; l++) begin
            if (CNT_W'(l) < count) begin
               rast_q_f[32*l +: 32] = lane[l].q_f;
               rast_r_f[32*l +: 32] = lane[l].r_f;
               rast_s_f[32*l +: 32] = lane[l].s_f;
            end
         end
      end
   end

   always_comb begin
      res_id    = '0;
      res_q     = '0;
      res_r     = '0;
      res_depth = '0;
      if (state == DRAIN) begin
         res_id    = lane[idx].id;
         res_q     = res_buf[idx].q;
         res_r     = res_buf[idx].r;
         res_depth = res_buf[idx].depth;
      end
   end

endmodule

// File: tb/tb_hex_raster_batch_scheduler.sv
// Bench for hex_raster_batch_scheduler: queue-based batch model checked every cycle plus directed literal checks.
module tb_hex_raster_batch_scheduler;

   localparam int LANES   = 10;
   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 16;
   localparam int ID_W    = 2;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*32-1:0]  req_q_f = '0;
   logic [NUM_REQ*32-1:0]  req_r_f = '0;
   logic [NUM_REQ*32-1:0]  req_s_f = '0;
   logic                   flush = 1'b0;
   logic                   rast_valid_in;
   logic [LANES*32-1:0]    rast_q_f, rast_r_f, rast_s_f;
   logic                   rast_valid_out = 1'b0;
   logic [LANES*16-1:0]    rast_q = '0;
   logic [LANES*16-1:0]    rast_r = '0;
   logic [LANES*8-1:0]     rast_depth = '0;
   logic                   res_valid;
   logic                   res_ready = 1'b1;
   logic [ID_W-1:0]        res_id;
   logic [15:0]            res_q, res_r;
   logic [7:0]             res_depth;
   logic                   busy, err_unexpected;

   hex_raster_batch_scheduler #(.LANES(LANES), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_q_f(req_q_f), .req_r_f(req_r_f), .req_s_f(req_s_f),
      .flush(flush),
      .rast_valid_in(rast_valid_in), .rast_q_f(rast_q_f), .rast_r_f(rast_r_f), .rast_s_f(rast_s_f),
      .rast_valid_out(rast_valid_out), .rast_q(rast_q), .rast_r(rast_r), .rast_depth(rast_depth),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_q(res_q), .res_r(res_r), .res_depth(res_depth),
      .busy(busy), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int id; logic [31:0] q; logic [31:0] r; logic [31:0] s; } samp_t;
   typedef struct { int id; logic [15:0] q; logic [15:0] r; logic [7:0] d; } out_t;

   samp_t m_batch[$];
   out_t  m_out[$];
   bit    m_launch = 0, m_waiting = 0, m_err = 0;
   int    m_age = 0, m_next = 0;

   int                  acc_cyc[$];
   int                  acc_id[$];
   int                  launch_cyc[$];
   logic [LANES*32-1:0] launch_q[$];
   out_t                drained[$];
   int                  drain_cyc[$];

   always @(negedge clk) begin
      bit filling, draining;
      int g, old_n;
      logic [NUM_REQ-1:0]  e_ready;
      logic [LANES*32-1:0] eq, er, es;
      logic [ID_W+40:0]    e_res;
      samp_t sm;
      out_t  o;

      if (!reset_n) begin
         m_batch.delete(); m_out.delete();
         m_launch = 0; m_waiting = 0; m_err = 0; m_age = 0; m_next = 0;
      end
      filling  = !m_launch && !m_waiting && m_out.size() == 0;
      draining = !m_launch && !m_waiting && m_out.size() != 0;

      g = -1;
      if (filling && reset_n)
         for (int k = 0; k < NUM_REQ; k++)
            if (g < 0 && req_valid[(m_next + k) % NUM_REQ]) g = (m_next + k) % NUM_REQ;
      e_ready = (g >= 0) ? NUM_REQ'(1) << g : '0;

      eq = '0; er = '0; es = '0;
      if (m_launch)
         for (int k = 0; k < m_batch.size(); k++) begin
            eq[32*k +: 32] = m_batch[k].q;
            er[32*k +: 32] = m_batch[k].r;
            es[32*k +: 32] = m_batch[k].s;
         end
      e_res = '0;
      if (draining) begin
         o = m_out[0];
         e_res = {1'b1, ID_W'(o.id), o.q, o.r, o.d};
      end

      chk("req_ready", req_ready, e_ready);
      chk("rast_valid_in", rast_valid_in, m_launch);
      chk("rast_q_f", rast_q_f, eq);
      chk("rast_r_f", rast_r_f, er);
      chk("rast_s_f", rast_s_f, es);
      chk("res", {res_valid, res_id, res_q, res_r, res_depth}, e_res);
      chk("busy", busy, !filling || m_batch.size() != 0);
      chk("err_unexpected", err_unexpected, m_err);

      if (reset_n) begin
         if ((req_ready & req_valid) != '0) begin
            acc_cyc.push_back(cyc);
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) acc_id.push_back(k);
         end
         if (rast_valid_in) begin
            launch_cyc.push_back(cyc);
            launch_q.push_back(rast_q_f);
         end
         if (res_valid && res_ready) begin
            o.id = int'(res_id); o.q = res_q; o.r = res_r; o.d = res_depth;
            drained.push_back(o);
            drain_cyc.push_back(cyc);
         end

         if (rast_valid_out && !m_waiting) m_err = 1;
         if (filling) begin
            old_n = m_batch.size();
            if (old_n > 0) m_age++;
            if (g >= 0) begin
               sm.id = g; sm.q = req_q_f[32*g +: 32]; sm.r = req_r_f[32*g +: 32]; sm.s = req_s_f[32*g +: 32];
               m_batch.push_back(sm);
               m_next = (g + 1) % NUM_REQ;
            end
            // m_age counts non-empty fill cycles; the TIMEOUT-th one forces the batch out.
            if (m_batch.size() == LANES || (old_n > 0 && (m_age == TIMEOUT || flush))) m_launch = 1;
         end else if (m_launch) begin
            m_launch = 0; m_waiting = 1;
         end else if (m_waiting) begin
            if (rast_valid_out) begin
               for (int k = 0; k < m_batch.size(); k++) begin
                  o.id = m_batch[k].id; o.q = rast_q[16*k +: 16]; o.r = rast_r[16*k +: 16]; o.d = rast_depth[8*k +: 8];
                  m_out.push_back(o);
               end
               m_batch.delete(); m_age = 0; m_waiting = 0;
            end
         end else if (res_ready) begin
            void'(m_out.pop_front());
         end
      end
   end

   // ---------------- rasterizer stand-in ----------------
   int rast_lat = 1;
   bit stub_en = 1;
   int stub_cnt = 0;
   int man_req = 0, man_done = 0;
   logic [LANES*32-1:0] cap_q, cap_r, cap_s;

   always @(posedge clk) begin
      #1;
      rast_valid_out = 1'b0;
      if (!reset_n) stub_cnt = 0;
      if (stub_cnt > 0) begin
         stub_cnt--;
         if (stub_cnt == 0) begin
            rast_valid_out = 1'b1;
            for (int k = 0; k < LANES; k++) begin
               rast_q[16*k +: 16]   = cap_q[32*k+16 +: 16];
               rast_r[16*k +: 16]   = cap_r[32*k+16 +: 16];
               rast_depth[8*k +: 8] = cap_s[32*k+16 +: 8] + 8'(k);
            end
         end
      end
      if (man_req != man_done) begin
         rast_valid_out = 1'b1;
         man_done = man_req;
      end
      if (rast_valid_in && stub_en && reset_n) begin
         cap_q = rast_q_f; cap_r = rast_r_f; cap_s = rast_s_f;
         stub_cnt = rast_lat;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [31:0] q, input logic [31:0] r, input logic [31:0] s);
      bit ok = 0;
      req_q_f[32*i +: 32] = q;
      req_r_f[32*i +: 32] = r;
      req_s_f[32*i +: 32] = s;
      req_valid[i] = 1'b1;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (req_ready[i]) ok = 1;
      end
      tick();
      req_valid[i] = 1'b0;
      chk("send_accepted", ok, 1'b1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (!busy) ok = 1;
      end
      tick();
      chk("wait_idle", ok, 1'b1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int bl, bd, ba, last, first, fl_cyc;
      bit ok;
      logic [LANES*32-1:0] lv, ev;
      logic [63:0] hold;
      int exp_ids[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};

      // Reset with every requester asserting valid: all outputs must stay 0.
      tick();
      req_valid = '1;
      tick();
      @(negedge clk);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_err", err_unexpected, 0);
      chk("reset_res_valid", res_valid, 0);
      tick();
      req_valid = '0;
      reset_n = 1'b1;
      tick();

      // T1: requester 0 streams 10 samples, q_f = k<<16.
      bl = launch_cyc.size(); bd = drained.size();
      for (int k = 0; k < 10; k++) send(0, k << 16, (k + 32) << 16, (k + 64) << 16);
      last = acc_cyc[acc_cyc.size() - 1];
      wait_idle();
      chk("t1_launches", launch_cyc.size() - bl, 1);
      chk("t1_issue_latency", launch_cyc[bl] - last, 1);
      chk("t1_first_result_latency", drain_cyc[bd] - last, 3);
      ev = '0;
      for (int k = 0; k < 10; k++) ev[32*k +: 32] = k << 16;
      chk("t1_lane_q_f", launch_q[bl], ev);
      chk("t1_result_count", drained.size() - bd, 10);
      if (drained.size() >= bd + 10)
         for (int k = 0; k < 10; k++) begin
            chk("t1_res_id", drained[bd+k].id, 0);
            chk("t1_res_q", drained[bd+k].q, k);
            chk("t1_res_r", drained[bd+k].r, k + 32);
         end

      // T2: all requesters valid -> grants rotate 0,1,2,3,...
      do_reset();
      bl = launch_cyc.size(); bd = drained.size(); ba = acc_id.size();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_q_f[32*i +: 32] = (i + 5) << 16;
         req_r_f[32*i +: 32] = (i + 9) << 16;
         req_s_f[32*i +: 32] = (i + 1) << 16;
      end
      req_valid = '1;
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (rast_valid_in) ok = 1;
      end
      chk("t2_launch_seen", ok, 1'b1);
      tick();
      req_valid = '0;
      wait_idle();
      chk("t2_accept_count", acc_id.size() - ba, 10);
      chk("t2_result_count", drained.size() - bd, 10);
      if (acc_id.size() >= ba + 10 && drained.size() >= bd + 10)
         for (int k = 0; k < 10; k++) begin
            chk("t2_grant_id", acc_id[ba+k], exp_ids[k]);
            chk("t2_res_id", drained[bd+k].id, exp_ids[k]);
            chk("t2_res_q", drained[bd+k].q, exp_ids[k] + 5);
         end

      // T3: 3 samples then idle -> forced out by timeout.
      bl = launch_cyc.size(); bd = drained.size(); ba = acc_cyc.size();
      for (int k = 0; k < 3; k++) send(2, (k + 1) << 16, (k + 2) << 16, (k + 3) << 16);
      first = acc_cyc[ba];
      wait_idle();
      chk("t3_launches", launch_cyc.size() - bl, 1);
      // Cycles first+1..first+TIMEOUT are the counted fill cycles; launch follows.
      chk("t3_issue_cycle", launch_cyc[bl] - first, TIMEOUT + 1);
      lv = launch_q[bl];
      chk("t3_upper_lanes_zero", lv[LANES*32-1:96], 0);
      chk("t3_lane2_q_f", lv[95:64], 32'h0003_0000);
      chk("t3_result_count", drained.size() - bd, 3);

      // T4: flush on an empty batch is ignored; flush after 5 samples issues next cycle.
      bl = launch_cyc.size(); bd = drained.size();
      flush = 1'b1;
      repeat (2) tick();
      flush = 1'b0;
      repeat (3) tick();
      chk("t4_empty_flush_no_launch", launch_cyc.size() - bl, 0);
      @(negedge clk);
      chk("t4_empty_flush_busy", busy, 0);
      tick();
      for (int k = 0; k < 5; k++) send(1, (k + 20) << 16, (k + 40) << 16, (k + 60) << 16);
      flush = 1'b1;
      @(negedge clk);
      fl_cyc = cyc;
      tick();
      flush = 1'b0;
      wait_idle();
      chk("t4_flush_issue", launch_cyc[bl] - fl_cyc, 1);
      chk("t4_result_count", drained.size() - bd, 5);
      // Flush raised together with the 2nd sample: that sample still joins.
      bd = drained.size();
      send(3, 32'h0007_0000, 32'h0008_0000, 32'h0009_0000);
      flush = 1'b1;
      send(3, 32'h000A_0000, 32'h000B_0000, 32'h000C_0000);
      flush = 1'b0;
      wait_idle();
      chk("t4_flush_with_handshake_count", drained.size() - bd, 2);

      // T5: downstream stalls during DRAIN, rasterizer latency 3.
      rast_lat = 3;
      res_ready = 1'b0;
      bd = drained.size();
      for (int k = 0; k < 4; k++) send(2, (k + 70) << 16, (k + 80) << 16, (k + 90) << 16);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (res_valid) ok = 1;
      end
      chk("t5_res_valid_seen", ok, 1'b1);
      hold = {23'd0, res_valid, res_id, res_q, res_r, res_depth};
      chk("t5_first_res_q", res_q, 16'd70);
      for (int t = 0; t < 4; t++) begin
         tick();
         if (t == 0) begin
            req_q_f[31:0] = 32'h00AA_0000;
            req_valid[0] = 1'b1;
         end
         @(negedge clk);
         chk("t5_res_held", {23'd0, res_valid, res_id, res_q, res_r, res_depth}, hold);
         chk("t5_req_ready_low", req_ready, 0);
      end
      tick();
      res_ready = 1'b1;
      ok = 0;
      for (int t = 0; t < 30 && !ok; t++) begin
         @(negedge clk);
         if (req_ready[0]) ok = 1;
      end
      tick();
      req_valid[0] = 1'b0;
      chk("t5_accept_after_drain", ok && (acc_cyc[acc_cyc.size()-1] > drain_cyc[drain_cyc.size()-1]), 1'b1);
      chk("t5_drained_before_accept", drained.size() - bd, 4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_idle();
      chk("t5_total_results", drained.size() - bd, 5);
      rast_lat = 1;

      // T6: reset while waiting on the rasterizer, then a stray result pulse.
      stub_en = 0;
      bl = launch_cyc.size();
      send(1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
      send(1, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (launch_cyc.size() > bl) ok = 1;
      end
      chk("t6_launch_seen", ok, 1'b1);
      repeat (3) tick();
      @(negedge clk);
      chk("t6_busy_in_wait", busy, 1);
      bd = drained.size();
      tick();
      reset_n = 1'b0;
      tick();
      @(negedge clk);
      chk("t6_reset_outputs", {req_ready, rast_valid_in, res_valid, busy, err_unexpected, res_q, res_depth}, 0);
      chk("t6_reset_rast_q_f", rast_q_f, 0);
      tick();
      reset_n = 1'b1;
      tick();
      man_req++;
      repeat (2) tick();
      @(negedge clk);
      chk("t6_err_sticky", err_unexpected, 1);
      repeat (10) tick();
      chk("t6_no_results", drained.size() - bd, 0);
      @(negedge clk);
      chk("t6_idle_after", {busy, res_valid}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_raster_batch_scheduler.md
Name: hex_raster_batch_scheduler

Overview:
- Shares one 10-lane hexagonal rasterizer between NUM_REQ upstream requesters (primitive setup units).
- Packs single hex samples (fixed-point q/r/s) from round-robin-arbitrated requesters into one batch and fires the rasterizer once.
- Captures the per-lane results and drains them serially back, each tagged with its originating requester.

Parameters:
- LANES, 10, rasterizer lane count; must match the rasterizer.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, FILL cycles after the first accepted sample before a partial batch is forced out (>=1).
- ID_W, 2, requester id width; equals clog2(NUM_REQ).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_q_f  in  NUM_REQ*32  packed q fixed-point (16.16) per requester.
- req_r_f  in  NUM_REQ*32  packed r per requester.
- req_s_f  in  NUM_REQ*32  packed s per requester.
- flush  in  1  force issue of a partial batch.
- rast_valid_in  out  1  one-cycle rasterizer launch.
- rast_q_f, rast_r_f, rast_s_f  out  LANES*32 each  packed lane operands.
- rast_valid_out  in  1  rasterizer result valid.
- rast_q, rast_r  in  LANES*16 each  lane results.
- rast_depth  in  LANES*8  lane depth.
- res_valid  out  1  serial result valid.
- res_ready  in  1  downstream accept.
- res_id  out  ID_W  requester of the current result.
- res_q, res_r  out  16 each  result coordinates.
- res_depth  out  8  result depth.
- busy  out  1  high whenever state != FILL or lane count != 0.
- err_unexpected  out  1  sticky: rast_valid_out seen outside WAIT.

Behaviour:
- The block has one clock (clk). reset is asynchronous and active-low (reset_n).
- Asserting reset_n low at any time, mid-batch included, immediately clears every register:
  - state=FILL, count=0, timer=0, rr pointer=0, err_unexpected=0.
  - All outputs 0; held lane data is discarded.
- FSM states: FILL, ISSUE, WAIT, DRAIN.
- FILL:
  - Grant goes to the first requester with req_valid set, searching from rr pointer upward with wrap-around.
  - req_ready is high for the granted requester only. Handshake = valid & ready.
  - An accepted sample goes to lane[count] with its id; then count++ and rr pointer = grant+1 mod NUM_REQ.
  - timer increments every FILL cycle while count>0 (before the increment).
  - Go to ISSUE when the handshake makes count==LANES, or when count>0 and (timer==TIMEOUT-1 or flush).
  - A handshake in the same cycle as a timeout or flush is still accepted and included in the batch.
  - flush with count==0 is ignored.
- ISSUE:
  - Exactly one cycle with rast_valid_in=1.
  - Lanes >= count are driven as 0.
  - req_ready is all 0 in ISSUE, WAIT and DRAIN.
  - Next state WAIT.
- WAIT:
  - Hold until rast_valid_out, with no latency bound.
  - Capture rast_q/r/depth into the result buffer for lanes < count, then go to DRAIN with idx=0.
  - rast_valid_out in any other state is ignored and sets err_unexpected.
- DRAIN:
  - res_valid=1; res_* driven from buffer[idx] and res_id from lane id[idx].
  - Outputs are held stable while res_ready=0.
  - On res_ready, idx++. After idx count-1 is accepted, go to FILL with count=0 and timer=0.
- Latency at rasterizer latency 1:
  - 10th sample accepted in cycle N; rast_valid_in in cycle N+1.
  - rast_valid_out in cycle N+2; first res_valid in cycle N+3.
- Order: results leave in lane order, which is acceptance order.
- Width: q_f/r_f/s_f pass through unmodified; no arithmetic in this block.

Test Plan:
- Single requester 0 streams 10 samples (q_f=k<<16, k=0..9) -> rast_valid_in pulses once with lane k q_f=k<<16; 10 results with res_id=0 and res_q=k, in order.
- All 4 requesters valid continuously -> grants cycle 0,1,2,3,0,1,...; lanes 0..9 carry ids 0,1,2,3,0,1,2,3,0,1.
- 3 samples, then idle, TIMEOUT=16 -> rast_valid_in 16 FILL cycles after the first accept; lanes 3..9 zero; exactly 3 results drained.
- 5 samples, then flush -> issue the next cycle; flush with an empty batch causes no rast_valid_in.
- res_ready low for 4 cycles during DRAIN -> res_valid and res_* held; req_ready stays 0 until the last result is accepted.
- reset_n low during WAIT, then rast_valid_out pulse after release -> all outputs 0 during reset; err_unexpected=1 afterwards; no results emitted.
